// File: rtl/mips_multicycle_ctrl_if.sv
// Unified-memory handshake between the multicycle control unit and memory.
// The controller (master) raises mem_req with memwrite/iord; memory (slave)
// answers with mem_ready in the cycle the access completes.
interface mips_multicycle_ctrl_if;
  logic mem_req;
  logic memwrite;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output memwrite, output iord, input mem_ready);
  modport slave  (input mem_req, input memwrite, input iord, output mem_ready);
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/execute/memory/writeback
// per instruction, drives datapath enables, mux selects and ALU control, waits
// on a ready-handshaked memory, flags illegal instructions and latches a sticky
// fault when a memory access stalls for MEM_TIMEOUT cycles.
// Optional feature macro: BNE_EN (adds bne as a BRANCH with inverted zero test).
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALUCTRL_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [5:0]               opcode,
  input  logic [5:0]               funct,
  input  logic                     zero,
  mips_multicycle_ctrl_if.master   mem,
  output logic                     irwrite,
  output logic                     pc_en,
  output logic                     regwrite,
  output logic                     regdst,
  output logic                     memtoreg,
  output logic                     alusrca,
  output logic [1:0]               alusrcb,
  output logic [1:0]               pcsrc,
  output logic [ALUCTRL_W-1:0]     alucontrol,
  output logic [3:0]               state_o,
  output logic                     illegal,
  output logic                     fault
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12, S_FAULT  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // R-type funct codes the datapath supports
  function automatic logic funct_ok(input logic [5:0] f);
    case (f)
      6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42: funct_ok = 1'b1;
      default:                                  funct_ok = 1'b0;
    endcase
  endfunction

  // R-type funct to ALU operation
  function automatic logic [3:0] funct_alu(input logic [5:0] f);
    case (f)
      6'd32:   funct_alu = ALU_ADD;
      6'd34:   funct_alu = ALU_SUB;
      6'd36:   funct_alu = ALU_AND;
      6'd37:   funct_alu = ALU_OR;
      6'd39:   funct_alu = ALU_NOR;
      6'd42:   funct_alu = ALU_SLT;
      default: funct_alu = ALU_ADD;
    endcase
  endfunction

  // DECODE successor; S_FETCH doubles as the "unsupported instruction" result
  function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] f);
    case (op)
      OP_LW, OP_SW: decode_target = S_MEMADR;
      OP_RTYPE:     decode_target = funct_ok(f) ? S_EXEC : S_FETCH;
      OP_BEQ:       decode_target = S_BRANCH;
`ifdef BNE_EN
      OP_BNE:       decode_target = S_BRANCH;
`endif
      OP_ADDI:      decode_target = S_ADDIEX;
      OP_J:         decode_target = S_JUMP;
      default:      decode_target = S_FETCH;
    endcase
  endfunction

  state_t             r_state;
  logic [CNT_W-1:0]   r_wait_cnt;
  state_t             w_decode_next;
  logic               w_timeout;
  logic               w_branch_take;
  logic [3:0]         w_alu4;

  assign w_decode_next = decode_target(opcode, funct);
  assign w_timeout     = (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

`ifdef BNE_EN
  assign w_branch_take = (opcode == OP_BNE) ? ~zero : zero;
`else
  assign w_branch_take = zero;
`endif

  // State sequencing and memory-wait counter; the counter is zero whenever a
  // memory state is entered because every way out of one clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_wait_cnt <= '0;
        end
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (mem.mem_ready) begin
            r_wait_cnt <= '0;
            if (r_state == S_FETCH)      r_state <= S_DECODE;
            else if (r_state == S_MEMRD) r_state <= S_MEMWB;
            else                         r_state <= S_FETCH;
          end else if (w_timeout) begin
            r_wait_cnt <= '0;
            r_state    <= S_FAULT;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          r_state    <= w_decode_next;
          r_wait_cnt <= '0;
        end
        S_MEMADR: begin
          r_state    <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
          r_wait_cnt <= '0;
        end
        S_EXEC:   r_state <= S_ALUWB;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
          r_state    <= S_FETCH;
          r_wait_cnt <= '0;
        end
        S_FAULT:  r_state <= S_FAULT;
        default: begin
          r_state    <= S_FAULT;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // Datapath controls decoded from the current state (plus mem_ready/zero)
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.memwrite = 1'b0;
    mem.iord     = 1'b0;
    irwrite      = 1'b0;
    pc_en        = 1'b0;
    regwrite     = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    w_alu4       = 4'b0000;
    illegal      = 1'b0;
    fault        = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        alusrcb     = 2'b01;
        w_alu4      = ALU_ADD;
        irwrite     = mem.mem_ready;
        pc_en       = mem.mem_ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        w_alu4  = ALU_ADD;
        illegal = (w_decode_next == S_FETCH);
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_alu4  = ALU_ADD;
      end
      S_MEMRD: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        mem.mem_req  = 1'b1;
        mem.iord     = 1'b1;
        mem.memwrite = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        w_alu4  = funct_alu(funct);
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        w_alu4  = ALU_SUB;
        pcsrc   = 2'b01;
        pc_en   = w_branch_take;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc = 2'b10;
        pc_en = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: fault = 1'b0;
    endcase
  end

  assign alucontrol = ALUCTRL_W'(w_alu4);
  assign state_o    = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: each step drives inputs, queues the
// expected output vector, and pops/compares it at the following falling edge.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       irwrite, pc_en, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol;
  logic [3:0] state_o;
  logic       illegal, fault;

  mips_multicycle_ctrl_if u_if ();

  mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .ALUCTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem(u_if), .irwrite(irwrite), .pc_en(pc_en), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .state_o(state_o),
    .illegal(illegal), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [22:0] exp;
    string       tag;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  // Vector layout: state, mem_req, memwrite, iord, irwrite, pc_en, regwrite,
  // regdst, memtoreg, alusrca, alusrcb, pcsrc, alucontrol, illegal, fault
  function automatic logic [22:0] mk(
    input logic [3:0] st, input logic req, input logic wr, input logic io,
    input logic irw, input logic pce, input logic rw, input logic rd,
    input logic m2r, input logic asa, input logic [1:0] asb,
    input logic [1:0] pcs, input logic [3:0] alu, input logic ill, input logic flt);
    mk = {st, req, wr, io, irw, pce, rw, rd, m2r, asa, asb, pcs, alu, ill, flt};
  endfunction

  function automatic logic [22:0] e_idle();
    e_idle = mk(4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,4'b0000,1'b0,1'b0);
  endfunction
  function automatic logic [22:0] e_fetch(input logic r);
    e_fetch = mk(4'd1, 1'b1,1'b0,1'b0,r,r,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b00,4'b0010,1'b0,1'b0);
  endfunction
  function automatic logic [22:0] e_decode(input logic ill);
    e_decode = mk(4'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11,2'b00,4'b0010,ill,1'b0);
  endfunction
  function automatic logic [22:0] e_memadr();
    e_memadr = mk(4'd3, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10,2'b00,4'b0010,1'b0,1'b0);
  endfunction
  function automatic logic [22:0] e_memrd();
    e_memrd = mk(4'd4, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,4'b0000,1'b0,1'b0);
  endfunction
  function automatic logic [22:0] e_memwb();
    e_memwb = mk(4'd5, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 2'b00,2'b00,4'b0000,1'b0,1'b0);
  endfunction
  function automatic logic [22:0] e_memwr();
    e_memwr = mk(4'd6, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,4'b0000,1'b0,1'b0);
  endfunction
  function automatic logic [22:0] e_exec(input logic [3:0] alu);
    e_exec = mk(4'd7, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,alu,1'b0,1'b0);
  endfunction
  function automatic logic [22:0] e_aluwb();
    e_aluwb = mk(4'd8, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 2'b00,2'b00,4'b0000,1'b0,1'b0);
  endfunction
  function automatic logic [22:0] e_branch(input logic pce);
    e_branch = mk(4'd9, 1'b0,1'b0,1'b0,1'b0,pce,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b01,4'b0110,1'b0,1'b0);
  endfunction
  function automatic logic [22:0] e_addiex();
    e_addiex = mk(4'd10, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10,2'b00,4'b0010,1'b0,1'b0);
  endfunction
  function automatic logic [22:0] e_addiwb();
    e_addiwb = mk(4'd11, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00,4'b0000,1'b0,1'b0);
  endfunction
  function automatic logic [22:0] e_jump();
    e_jump = mk(4'd12, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,4'b0000,1'b0,1'b0);
  endfunction
  function automatic logic [22:0] e_fault();
    e_fault = mk(4'd15, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,4'b0000,1'b0,1'b1);
  endfunction

  function automatic logic [22:0] observed();
    observed = {state_o, u_if.mem_req, u_if.memwrite, u_if.iord, irwrite, pc_en,
                regwrite, regdst, memtoreg, alusrca, alusrcb, pcsrc, alucontrol,
                illegal, fault};
  endfunction

  // Pop the oldest expectation and compare it against the live outputs
  task automatic check_front();
    sb_t e;
    logic [22:0] obs;
    e   = sb_q.pop_front();
    obs = observed();
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  // One clock cycle: drive inputs (just after posedge), queue expectation,
  // compare at negedge, then advance to just after the next posedge
  task automatic step(input logic rdy, input logic z, input logic [5:0] op,
                      input logic [5:0] fn, input logic [22:0] exp, input string tag);
    sb_t e;
    u_if.mem_ready = rdy;
    zero           = z;
    opcode         = op;
    funct          = fn;
    e.exp = exp;
    e.tag = tag;
    sb_q.push_back(e);
    @(negedge clk);
    check_front();
    @(posedge clk);
    #1;
  endtask

  // Bring the DUT out of reset and land in FETCH on the next posedge
  task automatic do_reset();
    sb_t e;
    rst_n = 1'b0;
    #1;
    e.exp = e_idle();
    e.tag = "reset_idle";
    sb_q.push_back(e);
    check_front();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 6'd0, 6'd0, e_idle(), "idle");
  endtask

  initial begin
    rst_n          = 1'b0;
    u_if.mem_ready = 1'b0;
    zero           = 1'b0;
    opcode         = 6'd0;
    funct          = 6'd0;
    @(posedge clk);
    #1;
    do_reset();

    // lw with memory always ready: 0,1,2,3,4,5 then FETCH
    step(1'b1, 1'b0, 6'b100011, 6'd0, e_fetch(1'b1), "lw_fetch");
    step(1'b1, 1'b0, 6'b100011, 6'd0, e_decode(1'b0), "lw_decode");
    step(1'b1, 1'b0, 6'b100011, 6'd0, e_memadr(), "lw_memadr");
    step(1'b1, 1'b0, 6'b100011, 6'd0, e_memrd(), "lw_memrd");
    step(1'b1, 1'b0, 6'b100011, 6'd0, e_memwb(), "lw_memwb");

    // sw with three not-ready cycles in MEMWR
    step(1'b1, 1'b0, 6'b101011, 6'd0, e_fetch(1'b1), "sw_fetch");
    step(1'b1, 1'b0, 6'b101011, 6'd0, e_decode(1'b0), "sw_decode");
    step(1'b1, 1'b0, 6'b101011, 6'd0, e_memadr(), "sw_memadr");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 6'b101011, 6'd0, e_memwr(), "sw_memwr_wait");
    step(1'b1, 1'b0, 6'b101011, 6'd0, e_memwr(), "sw_memwr_done");

    // R-type and / slt
    step(1'b1, 1'b0, 6'b000000, 6'd36, e_fetch(1'b1), "and_fetch");
    step(1'b1, 1'b0, 6'b000000, 6'd36, e_decode(1'b0), "and_decode");
    step(1'b1, 1'b0, 6'b000000, 6'd36, e_exec(4'b0000), "and_exec");
    step(1'b1, 1'b0, 6'b000000, 6'd36, e_aluwb(), "and_aluwb");
    step(1'b1, 1'b0, 6'b000000, 6'd42, e_fetch(1'b1), "slt_fetch");
    step(1'b1, 1'b0, 6'b000000, 6'd42, e_decode(1'b0), "slt_decode");
    step(1'b1, 1'b0, 6'b000000, 6'd42, e_exec(4'b0111), "slt_exec");
    step(1'b1, 1'b0, 6'b000000, 6'd42, e_aluwb(), "slt_aluwb");
    step(1'b1, 1'b0, 6'b000000, 6'd39, e_fetch(1'b1), "nor_fetch");
    step(1'b1, 1'b0, 6'b000000, 6'd39, e_decode(1'b0), "nor_decode");
    step(1'b1, 1'b0, 6'b000000, 6'd39, e_exec(4'b1100), "nor_exec");
    step(1'b1, 1'b0, 6'b000000, 6'd39, e_aluwb(), "nor_aluwb");

    // Illegal funct=0: pulse in DECODE, straight back to FETCH
    step(1'b1, 1'b0, 6'b000000, 6'd0, e_fetch(1'b1), "ill_fetch");
    step(1'b1, 1'b0, 6'b000000, 6'd0, e_decode(1'b1), "ill_decode");

    // beq taken / not taken
    step(1'b1, 1'b1, 6'b000100, 6'd0, e_fetch(1'b1), "beq1_fetch");
    step(1'b1, 1'b1, 6'b000100, 6'd0, e_decode(1'b0), "beq1_decode");
    step(1'b1, 1'b1, 6'b000100, 6'd0, e_branch(1'b1), "beq1_branch");
    step(1'b1, 1'b0, 6'b000100, 6'd0, e_fetch(1'b1), "beq0_fetch");
    step(1'b1, 1'b0, 6'b000100, 6'd0, e_decode(1'b0), "beq0_decode");
    step(1'b1, 1'b0, 6'b000100, 6'd0, e_branch(1'b0), "beq0_branch");

    // j
    step(1'b1, 1'b0, 6'b000010, 6'd0, e_fetch(1'b1), "j_fetch");
    step(1'b1, 1'b0, 6'b000010, 6'd0, e_decode(1'b0), "j_decode");
    step(1'b1, 1'b0, 6'b000010, 6'd0, e_jump(), "j_jump");

    // addi
    step(1'b1, 1'b0, 6'b001000, 6'd0, e_fetch(1'b1), "addi_fetch");
    step(1'b1, 1'b0, 6'b001000, 6'd0, e_decode(1'b0), "addi_decode");
    step(1'b1, 1'b0, 6'b001000, 6'd0, e_addiex(), "addi_ex");
    step(1'b1, 1'b0, 6'b001000, 6'd0, e_addiwb(), "addi_wb");

    // bne with zero=0
    step(1'b1, 1'b0, 6'b000101, 6'd0, e_fetch(1'b1), "bne_fetch");
`ifdef BNE_EN
    step(1'b1, 1'b0, 6'b000101, 6'd0, e_decode(1'b0), "bne_decode");
    step(1'b1, 1'b0, 6'b000101, 6'd0, e_branch(1'b1), "bne_branch");
`else
    step(1'b1, 1'b0, 6'b000101, 6'd0, e_decode(1'b1), "bne_illegal");
`endif

    // FETCH wait: ready on the 16th cycle still wins over the timeout
    for (int i = 0; i < 15; i++)
      step(1'b0, 1'b0, 6'b000010, 6'd0, e_fetch(1'b0), "late_fetch_wait");
    step(1'b1, 1'b0, 6'b000010, 6'd0, e_fetch(1'b1), "late_fetch_ready");
    step(1'b1, 1'b0, 6'b000010, 6'd0, e_decode(1'b0), "late_decode");
    step(1'b1, 1'b0, 6'b000010, 6'd0, e_jump(), "late_jump");

    // FETCH timeout: 16 not-ready cycles then sticky FAULT
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b0, 6'b100011, 6'd0, e_fetch(1'b0), "to_fetch_wait");
    step(1'b0, 1'b0, 6'b100011, 6'd0, e_fault(), "to_fault");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 6'b100011, 6'd0, e_fault(), "to_fault_sticky");
    do_reset();

    // Reset in the middle of a stalled FETCH drops mem_req at once
    step(1'b0, 1'b0, 6'b100011, 6'd0, e_fetch(1'b0), "mid_fetch");
    do_reset();
    step(1'b1, 1'b0, 6'b100011, 6'd0, e_fetch(1'b1), "post_reset_fetch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
